fetch_sequencer: RTL

- Multicycle fetch/issue controller for the RISC-V core.
- Sequences the PC and IR registers: drives their load strobes and next-PC value, handshakes with instruction memory and with the execute stage.
- One instruction in flight at a time. Detects misaligned branch targets; can optionally detect a memory fetch timeout.

---
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/issue controller: sequences PC/IR load strobes and handshakes
// with instruction memory and execute. Optional fetch timeout: define FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int                WIDTH          = 32,
    parameter logic [WIDTH-1:0]  RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic [WIDTH-1:0] pc,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    output logic             ir_load,
    output logic             ir_valid,
    input  logic             exec_ready,
    input  logic             exec_done,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_cause
);

    // Elaboration-time sanity checks on the configuration.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_sequencer: RESET_PC must be word aligned");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_FAULT
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

    state_t           state, state_nxt;
    logic [1:0]       cause_q, cause_nxt;
    logic [WIDTH-1:0] pc_inc;
    logic             target_ok;
    logic             timeout;

    assign pc_inc    = pc + WIDTH'(4);
    assign target_ok = !branch_taken || (branch_target[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // Counter sits at zero outside FETCH, so every FETCH entry starts from zero.
    always_ff @(posedge clk) begin
        if (!rstn)
            wait_cnt <= '0;
        else if (state == S_FETCH && !mem_ack)
            wait_cnt <= wait_cnt + CW'(1);
        else
            wait_cnt <= '0;
    end

    // Fires in the cycle the count would reach the limit; a same-cycle ack wins.
    assign timeout = (state == S_FETCH) && !mem_ack &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        mem_req   = 1'b0;
        ir_load   = 1'b0;
        ir_valid  = 1'b0;
        pc_load   = 1'b0;
        pc_next   = pc_inc;

        case (state)
            S_IDLE: begin
                if (run)
                    state_nxt = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_ISSUE;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end

            S_ISSUE: begin
                ir_valid = 1'b1;
                if (exec_ready)
                    state_nxt = S_EXEC;
            end

            S_EXEC: begin
                if (exec_done) begin
                    if (target_ok) begin
                        pc_load   = 1'b1;
                        if (branch_taken)
                            pc_next = branch_target;
                        state_nxt = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_nxt = S_FAULT;
                        cause_nxt = CAUSE_MISALIGN;
                    end
                end
            end

            S_FAULT: begin
                // Terminal until reset; all strobes stay at their defaults.
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy        = (state != S_IDLE) && (state != S_FAULT);
    assign fault       = (state == S_FAULT);
    assign fault_cause = cause_q;

endmodule
